// File: rtl/horizontal_forward.sv
// horizontal_forward: one-direction X-hop stage arbitrating local and neighbour traffic onto next/turn outputs
module horizontal_forward #(
    parameter int PACKET_WIDTH = 30,
    parameter int DX_MSB = 29,
    parameter int DX_LSB = 21,
    parameter bit DIRECTION = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PACKET_WIDTH-1:0] local_din,
    input  logic                    local_empty,
    output logic                    local_ren,
    input  logic [PACKET_WIDTH-1:0] nbr_din,
    input  logic                    nbr_empty,
    output logic                    nbr_ren,
    output logic [PACKET_WIDTH-1:0] next_dout,
    output logic                    next_wen,
    input  logic                    next_full,
    output logic [DX_LSB-1:0]       turn_dout,
    output logic                    turn_wen,
    input  logic                    turn_full,
    output logic                    err_dir
);
    localparam int DXW = DX_MSB - DX_LSB + 1;
    logic           rr;
    logic [DXW-1:0] local_dx, nbr_dx, sel_dx, hop_dx;
    logic           local_zero, nbr_zero, local_bad, nbr_bad, local_next, nbr_next;
    logic           next_blocked, turn_blocked, local_ok, nbr_ok;
    logic           serve_local, serve_nbr, serve, sel_bad, sel_next, sel_turn;
    logic [PACKET_WIDTH-1:0] sel_pkt;
    // classify both heads, decide eligibility and pick at most one source
    always_comb begin
        local_dx     = local_din[DX_MSB:DX_LSB];
        nbr_dx       = nbr_din[DX_MSB:DX_LSB];
        local_zero   = local_dx == '0;
        nbr_zero     = nbr_dx == '0;
        local_bad    = !local_zero && (local_dx[DXW-1] != DIRECTION);
        nbr_bad      = !nbr_zero && (nbr_dx[DXW-1] != DIRECTION);
        local_next   = !local_zero && !local_bad;
        nbr_next     = !nbr_zero && !nbr_bad;
        next_blocked = next_full || next_wen;
        turn_blocked = turn_full || turn_wen;
        local_ok     = !local_empty && (local_bad || (local_next ? !next_blocked : !turn_blocked));
        nbr_ok       = !nbr_empty && (nbr_bad || (nbr_next ? !next_blocked : !turn_blocked));
        serve_nbr    = nbr_ok && (!local_ok || rr);
        serve_local  = local_ok && !serve_nbr;
        serve        = serve_local || serve_nbr;
        local_ren    = serve_local && !rst;
        nbr_ren      = serve_nbr && !rst;
        sel_pkt      = serve_nbr ? nbr_din : local_din;
        sel_dx       = serve_nbr ? nbr_dx : local_dx;
        sel_bad      = serve_nbr ? nbr_bad : local_bad;
        sel_next     = serve_nbr ? nbr_next : local_next;
        sel_turn     = serve && !sel_bad && !sel_next;
        hop_dx       = DIRECTION ? sel_dx + DXW'(1) : sel_dx - DXW'(1);
    end
    // register the served packet into its output, track errors and the round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_wen  <= 1'b0;
            turn_wen  <= 1'b0;
            err_dir   <= 1'b0;
            rr        <= 1'b0;
            next_dout <= '0;
            turn_dout <= '0;
        end else begin
            next_wen <= serve && sel_next;
            turn_wen <= sel_turn;
            err_dir  <= err_dir || (serve && sel_bad);
            if (serve && sel_next) next_dout <= {hop_dx, sel_pkt[DX_LSB-1:0]};
            if (sel_turn) turn_dout <= sel_pkt[DX_LSB-1:0];
            if (serve) rr <= serve_local;
        end
    end
endmodule

// File: tb/tb_horizontal_forward.sv
// tb_horizontal_forward: directed scenario checks of the eastbound horizontal_forward stage
module tb_horizontal_forward;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] local_din, nbr_din, next_dout;
    logic        local_empty, nbr_empty, local_ren, nbr_ren;
    logic        next_wen, next_full, turn_wen, turn_full, err_dir;
    logic [20:0] turn_dout;
    int errors = 0;
    int checks = 0;

    horizontal_forward dut (
        .clk(clk), .rst(rst),
        .local_din(local_din), .local_empty(local_empty), .local_ren(local_ren),
        .nbr_din(nbr_din), .nbr_empty(nbr_empty), .nbr_ren(nbr_ren),
        .next_dout(next_dout), .next_wen(next_wen), .next_full(next_full),
        .turn_dout(turn_dout), .turn_wen(turn_wen), .turn_full(turn_full),
        .err_dir(err_dir)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic [8:0] dx, input logic [20:0] pl);
        return {dx, pl};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        local_empty = 1'b1;
        nbr_empty = 1'b1;
        next_full = 1'b0;
        turn_full = 1'b0;
        local_din = '0;
        nbr_din = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_full = 1'b0;
        turn_full = 1'b0;
        local_din = mk(9'd1, 21'h000123);
        nbr_din = mk(9'd0, 21'h000456);
        local_empty = 1'b0;
        nbr_empty = 1'b0;
        @(negedge clk);
        checks++; if (next_wen !== 1'b0) begin errors++; $display("FAIL reset_next_wen: got %b want 0", next_wen); end
        checks++; if (turn_wen !== 1'b0) begin errors++; $display("FAIL reset_turn_wen: got %b want 0", turn_wen); end
        checks++; if (err_dir !== 1'b0) begin errors++; $display("FAIL reset_err_dir: got %b want 0", err_dir); end
        checks++; if (next_dout !== 30'h0) begin errors++; $display("FAIL reset_next_dout: got %h want 0", next_dout); end
        checks++; if (turn_dout !== 21'h0) begin errors++; $display("FAIL reset_turn_dout: got %h want 0", turn_dout); end
        checks++; if (local_ren !== 1'b0) begin errors++; $display("FAIL reset_local_ren: got %b want 0", local_ren); end
        checks++; if (nbr_ren !== 1'b0) begin errors++; $display("FAIL reset_nbr_ren: got %b want 0", nbr_ren); end
    endtask

    task automatic test_east_hop();
        do_reset();
        local_din = mk(9'd3, 21'h0ABCDE);
        local_empty = 1'b0;
        #1;
        checks++; if (local_ren !== 1'b1) begin errors++; $display("FAIL hop_local_ren: got %b want 1", local_ren); end
        checks++; if (nbr_ren !== 1'b0) begin errors++; $display("FAIL hop_nbr_ren: got %b want 0", nbr_ren); end
        @(negedge clk);
        checks++; if (next_wen !== 1'b1) begin errors++; $display("FAIL hop_next_wen: got %b want 1", next_wen); end
        checks++; if (next_dout !== mk(9'd2, 21'h0ABCDE)) begin errors++; $display("FAIL hop_next_dout: got %h want %h", next_dout, mk(9'd2, 21'h0ABCDE)); end
        checks++; if (turn_wen !== 1'b0) begin errors++; $display("FAIL hop_turn_wen: got %b want 0", turn_wen); end
        local_empty = 1'b1;
        @(negedge clk);
        checks++; if (next_wen !== 1'b0) begin errors++; $display("FAIL hop_wen_drop: got %b want 0", next_wen); end
        checks++; if (next_dout !== mk(9'd2, 21'h0ABCDE)) begin errors++; $display("FAIL hop_dout_hold: got %h want %h", next_dout, mk(9'd2, 21'h0ABCDE)); end
    endtask

    task automatic test_both_sources();
        do_reset();
        local_din = mk(9'd5, 21'h011111);
        nbr_din = mk(9'd0, 21'h155AA5);
        local_empty = 1'b0;
        nbr_empty = 1'b0;
        #1;
        checks++; if (local_ren !== 1'b1 || nbr_ren !== 1'b0) begin errors++; $display("FAIL both_c0_ren: got local=%b nbr=%b want local=1 nbr=0", local_ren, nbr_ren); end
        @(negedge clk);
        checks++; if (next_wen !== 1'b1) begin errors++; $display("FAIL both_next_wen: got %b want 1", next_wen); end
        checks++; if (next_dout !== mk(9'd4, 21'h011111)) begin errors++; $display("FAIL both_next_dout: got %h want %h", next_dout, mk(9'd4, 21'h011111)); end
        local_empty = 1'b1;
        #1;
        checks++; if (nbr_ren !== 1'b1 || local_ren !== 1'b0) begin errors++; $display("FAIL both_c1_ren: got local=%b nbr=%b want local=0 nbr=1", local_ren, nbr_ren); end
        @(negedge clk);
        checks++; if (turn_wen !== 1'b1) begin errors++; $display("FAIL both_turn_wen: got %b want 1", turn_wen); end
        checks++; if (turn_dout !== 21'h155AA5) begin errors++; $display("FAIL both_turn_dout: got %h want 155aa5", turn_dout); end
        checks++; if (next_wen !== 1'b0) begin errors++; $display("FAIL both_next_wen_low: got %b want 0", next_wen); end
        nbr_empty = 1'b1;
    endtask

    task automatic test_round_robin();
        logic exp_l [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_n [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic exp_tw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        local_din = mk(9'd0, 21'h000111);
        nbr_din = mk(9'd0, 21'h000222);
        local_empty = 1'b0;
        nbr_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (turn_wen !== exp_tw[i]) begin errors++; $display("FAIL rr_turn_wen c%0d: got %b want %b", i, turn_wen, exp_tw[i]); end
            if (i == 3) begin
                checks++; if (turn_dout !== 21'h000222) begin errors++; $display("FAIL rr_turn_dout: got %h want 000222", turn_dout); end
            end
            #1;
            checks++; if (local_ren !== exp_l[i] || nbr_ren !== exp_n[i]) begin errors++; $display("FAIL rr_ren c%0d: got local=%b nbr=%b want local=%b nbr=%b", i, local_ren, nbr_ren, exp_l[i], exp_n[i]); end
            @(negedge clk);
        end
        local_empty = 1'b1;
        nbr_empty = 1'b1;
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        logic served;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            local_empty = idx >= 4;
            local_din = mk(9'd1, 21'(idx + 1));
            #1;
            served = local_ren;
            checks++; if (local_ren !== (c % 2 == 0 && c <= 6)) begin errors++; $display("FAIL b2b_ren c%0d: got %b", c, local_ren); end
            @(negedge clk);
            checks++; if (next_wen !== (c % 2 == 0 && c <= 6)) begin errors++; $display("FAIL b2b_wen c%0d: got %b", c, next_wen); end
            if (c % 2 == 0 && c <= 6) begin
                checks++; if (next_dout !== mk(9'd0, 21'(c / 2 + 1))) begin errors++; $display("FAIL b2b_dout c%0d: got %h want %h", c, next_dout, mk(9'd0, 21'(c / 2 + 1))); end
            end
            if (served) idx++;
        end
        local_empty = 1'b1;
    endtask

    task automatic test_backpressure();
        do_reset();
        next_full = 1'b1;
        local_din = mk(9'd1, 21'h0C0C0C);
        nbr_din = mk(9'd0, 21'h1ABCDE);
        local_empty = 1'b0;
        nbr_empty = 1'b0;
        #1;
        checks++; if (nbr_ren !== 1'b1 || local_ren !== 1'b0) begin errors++; $display("FAIL bp_c0_ren: got local=%b nbr=%b want local=0 nbr=1", local_ren, nbr_ren); end
        @(negedge clk);
        checks++; if (turn_wen !== 1'b1 || turn_dout !== 21'h1ABCDE) begin errors++; $display("FAIL bp_turn: got wen=%b dout=%h want wen=1 dout=1abcde", turn_wen, turn_dout); end
        nbr_empty = 1'b1;
        #1;
        checks++; if (local_ren !== 1'b0) begin errors++; $display("FAIL bp_held_c1: got %b want 0", local_ren); end
        @(negedge clk);
        #1;
        checks++; if (local_ren !== 1'b0 || next_wen !== 1'b0) begin errors++; $display("FAIL bp_held_c2: got ren=%b wen=%b want 0 0", local_ren, next_wen); end
        next_full = 1'b0;
        #1;
        checks++; if (local_ren !== 1'b1) begin errors++; $display("FAIL bp_release_ren: got %b want 1", local_ren); end
        @(negedge clk);
        checks++; if (next_wen !== 1'b1 || next_dout !== mk(9'd0, 21'h0C0C0C)) begin errors++; $display("FAIL bp_release_write: got wen=%b dout=%h want wen=1 dout=%h", next_wen, next_dout, mk(9'd0, 21'h0C0C0C)); end
        local_empty = 1'b1;
    endtask

    task automatic test_wrong_direction();
        do_reset();
        nbr_din = mk(9'h1FE, 21'h012345);
        nbr_empty = 1'b0;
        #1;
        checks++; if (nbr_ren !== 1'b1) begin errors++; $display("FAIL bad_nbr_ren: got %b want 1", nbr_ren); end
        checks++; if (err_dir !== 1'b0) begin errors++; $display("FAIL bad_err_early: got %b want 0", err_dir); end
        @(negedge clk);
        checks++; if (err_dir !== 1'b1) begin errors++; $display("FAIL bad_err_set: got %b want 1", err_dir); end
        checks++; if (next_wen !== 1'b0 || turn_wen !== 1'b0) begin errors++; $display("FAIL bad_no_write: got next_wen=%b turn_wen=%b want 0 0", next_wen, turn_wen); end
        nbr_empty = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (err_dir !== 1'b1) begin errors++; $display("FAIL bad_err_sticky: got %b want 1", err_dir); end
    endtask

    task automatic test_reset_mid();
        local_din = mk(9'd3, 21'h0F00F0);
        nbr_din = mk(9'd0, 21'h000777);
        local_empty = 1'b0;
        #1;
        checks++; if (local_ren !== 1'b1) begin errors++; $display("FAIL mid_ren: got %b want 1", local_ren); end
        @(posedge clk);
        #2;
        nbr_empty = 1'b0;
        checks++; if (next_wen !== 1'b1) begin errors++; $display("FAIL mid_pre_wen: got %b want 1", next_wen); end
        rst = 1'b1;
        #1;
        checks++; if (next_wen !== 1'b0 || turn_wen !== 1'b0) begin errors++; $display("FAIL mid_wen_drop: got next=%b turn=%b want 0 0", next_wen, turn_wen); end
        checks++; if (err_dir !== 1'b0) begin errors++; $display("FAIL mid_err_clear: got %b want 0", err_dir); end
        checks++; if (local_ren !== 1'b0 || nbr_ren !== 1'b0) begin errors++; $display("FAIL mid_ren_drop: got local=%b nbr=%b want 0 0", local_ren, nbr_ren); end
        local_empty = 1'b1;
        nbr_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (next_wen !== 1'b0 || turn_wen !== 1'b0) begin errors++; $display("FAIL mid_no_write: got next=%b turn=%b want 0 0", next_wen, turn_wen); end
        end
        rst = 1'b1;
        @(negedge clk);
        local_din = mk(9'd2, 21'h00AAAA);
        local_empty = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (local_ren !== 1'b1) begin errors++; $display("FAIL first_serve_ren: got %b want 1", local_ren); end
        @(negedge clk);
        checks++; if (next_wen !== 1'b1 || next_dout !== mk(9'd1, 21'h00AAAA)) begin errors++; $display("FAIL first_serve_write: got wen=%b dout=%h want wen=1 dout=%h", next_wen, next_dout, mk(9'd1, 21'h00AAAA)); end
        local_empty = 1'b1;
    endtask

    initial begin
        test_reset();
        test_east_hop();
        test_both_sources();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_wrong_direction();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/horizontal_forward.md
HORIZONTAL_FORWARD -- requirements
Module: horizontal_forward

Interface
REQ-001 The block SHALL have parameter PACKET_WIDTH, default 30, meaning total packet width in bits.
REQ-002 The block SHALL have parameter DX_MSB, default 29, meaning the MSB of the signed dx field; DX_MSB equals PACKET_WIDTH-1.
REQ-003 The block SHALL have parameter DX_LSB, default 21, meaning the LSB of the signed dx field.
REQ-004 The block SHALL have parameter DIRECTION, default 0, meaning 0 = eastbound hop (dx >= 0) and 1 = westbound hop (dx <= 0).
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all state is on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1, an asynchronous active-high reset.
REQ-007 The block SHALL have port local_din, input, PACKET_WIDTH, the head of the local FWFT buffer for this direction.
REQ-008 The block SHALL have port local_empty, input, width 1, asserted when the local buffer is empty.
REQ-009 The block SHALL have port local_ren, output, width 1, a one-cycle pop of the local buffer.
REQ-010 The block SHALL have port nbr_din, input, PACKET_WIDTH, the head of the FWFT buffer fed by the upstream neighbour router.
REQ-011 The block SHALL have port nbr_empty, input, width 1, asserted when the neighbour buffer is empty.
REQ-012 The block SHALL have port nbr_ren, output, width 1, a one-cycle pop of the neighbour buffer.
REQ-013 The block SHALL have port next_dout, output, PACKET_WIDTH, the packet sent to the next router in DIRECTION.
REQ-014 The block SHALL have port next_wen, output, width 1, the write strobe for next_dout.
REQ-015 The block SHALL have port next_full, input, width 1, asserted when the next router's input buffer is full.
REQ-016 The block SHALL have port turn_dout, output, DX_LSB, the packet with the dx field stripped ([DX_LSB-1:0]), sent to the vertical stage.
REQ-017 The block SHALL have port turn_wen, output, width 1, the write strobe for turn_dout.
REQ-018 The block SHALL have port turn_full, input, width 1, asserted when the vertical-stage buffer is full.
REQ-019 The block SHALL have port err_dir, output, width 1, a sticky flag for a dropped wrong-direction packet.

Function
REQ-020 The block SHALL classify each head packet by signed dx: dx == 0 routes to turn; a nonzero dx of the correct sign for DIRECTION routes to next; a nonzero dx of the wrong sign is marked bad.
REQ-021 The block SHALL forward next-bound packets with dx replaced by dx-1 (DIRECTION 0) or dx+1 (DIRECTION 1), leaving all other bits unchanged; no overflow is possible.
REQ-022 The block SHALL treat a destination as blocked in a cycle when its full input is high or its own wen register is high (at most one write per destination every 2 cycles).
REQ-023 The block SHALL treat a source as eligible when it is not empty and either its packet is bad or its destination is not blocked.
REQ-024 The block SHALL serve at most one source per cycle, asserting that source's ren combinationally in the same cycle.
REQ-025 The block SHALL arbitrate with a 1-bit round-robin pointer rr (0 = local preferred): when both sources are eligible, the rr source is served and rr toggles; when one source is eligible, it is served and rr points to the other; when none is eligible, rr holds.
REQ-026 The block SHALL register a served good packet into next_dout/turn_dout, with the matching wen high for exactly the next cycle (latency 1); otherwise wen is low and dout holds its last value.
REQ-027 The block SHALL pop a served bad packet with no write and set err_dir on the following edge, holding it until rst.
REQ-028 A source that is not eligible SHALL stay un-popped (no ren) with its head unchanged; the other source may proceed.
REQ-029 The block SHALL never assert local_ren or nbr_ren while the corresponding empty input is high.

Reset
REQ-030 On rst high, independent of clk, the block SHALL force next_wen=0, turn_wen=0, err_dir=0, rr=0, next_dout=0, turn_dout=0; local_ren and nbr_ren SHALL be 0 while rst is high.
REQ-031 A packet whose wen register is set when rst asserts SHALL be discarded, with no write after reset release; the first serve can occur in the first cycle after deassertion.

Verification
REQ-032 DIRECTION=0, local dx=3 with nbr empty and next_full=0 -> local_ren in cycle 0; next_wen=1 in cycle 1 with dx=2 and the payload unchanged.
REQ-033 Local dx=5 and nbr dx=0 both present from reset -> local served first (to next), nbr served the next cycle (turn_wen, turn_dout = nbr_din[20:0]); rr alternates.
REQ-034 Four local next-bound packets, next_full=0 -> next_wen pattern 1,0,1,0,1,0,1 (one write per 2 cycles).
REQ-035 next_full=1 with local dx=1 and nbr dx=0 -> only nbr served; local held, local_ren=0 until next_full falls, then served.
REQ-036 DIRECTION=0, nbr dx=-2 -> nbr_ren pulse, no wen, err_dir=1 after the edge and held until rst.
REQ-037 rst asserted mid-cycle while next_wen=1 -> next_wen, turn_wen, err_dir and both rens drop to 0 immediately; no write occurs after release.
